// File: rtl/mv_timing_pkg.sv
`default_nettype none
// =====================================================================
// mv_timing_pkg : shared constants and state encoding for the
//                 video timing monitor.      Rev 1.0
// =====================================================================
package mv_timing_pkg;

  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACQUIRE = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;

  localparam int H_TOTAL_1080P  = 2200;
  localparam int H_ACTIVE_1080P = 1920;
  localparam int V_TOTAL_1080P  = 1125;
  localparam int V_ACTIVE_1080P = 1080;

endpackage
`default_nettype wire

// File: rtl/mv_edge_detect.sv
`default_nettype none
// =====================================================================
// mv_edge_detect : two-flop sampler giving level, rise and fall.
//                  Rev 1.0
// =====================================================================
module mv_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic q1_q, q2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign lvl_o  = q1_q;
  assign rise_o = q1_q & ~q2_q;
  assign fall_o = ~q1_q & q2_q;

endmodule
`default_nettype wire

// File: rtl/mv_timing_monitor.sv
`default_nettype none
// =====================================================================
// mv_timing_monitor : passive hs/vs/de line and frame timing checker.
//                     Rev 1.0
// =====================================================================
module mv_timing_monitor
  import mv_timing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic [CNT_W-1:0] exp_htotal_i,
  input  logic [CNT_W-1:0] exp_hactive_i,
  input  logic [CNT_W-1:0] exp_vtotal_i,
  input  logic [CNT_W-1:0] exp_vactive_i,
  input  logic             clr_error_i,
  output logic [CNT_W-1:0] meas_htotal_o,
  output logic [CNT_W-1:0] meas_hactive_o,
  output logic [CNT_W-1:0] meas_vtotal_o,
  output logic [CNT_W-1:0] meas_vactive_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             error_o,
  output logic [7:0]       frame_cnt_o
);

  localparam int               MW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};
  localparam logic [MW-1:0]    C_LOCK = MW'(LOCK_FRAMES);

  logic w_hs_lvl, w_hs_rise, w_hs_fall;
  logic w_vs_lvl, w_vs_rise, w_vs_fall;
  logic w_de_lvl, w_de_rise, w_de_fall;
  logic w_unused;

  mv_edge_detect u_hs_edge (.clk(clk), .rst_n(rst_n), .d_i(hs_i),
                            .lvl_o(w_hs_lvl), .rise_o(w_hs_rise), .fall_o(w_hs_fall));
  mv_edge_detect u_vs_edge (.clk(clk), .rst_n(rst_n), .d_i(vs_i),
                            .lvl_o(w_vs_lvl), .rise_o(w_vs_rise), .fall_o(w_vs_fall));
  mv_edge_detect u_de_edge (.clk(clk), .rst_n(rst_n), .d_i(de_i),
                            .lvl_o(w_de_lvl), .rise_o(w_de_rise), .fall_o(w_de_fall));

  assign w_unused = ^{w_hs_lvl, w_hs_fall, w_vs_lvl, w_vs_fall};

  logic [CNT_W-1:0]   pix_q, pix_d, de_cnt_q, de_cnt_d, line_q, line_d, vact_q, vact_d;
  logic [CNT_W-1:0]   line_len_q, line_len_d, act_len_q, act_len_d;
  logic               seen_hs_q, seen_hs_d, len_vld_q, len_vld_d, line_bad_q, line_bad_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   snap_ht_q, snap_ht_d, snap_ha_q, snap_ha_d;
  logic [CNT_W-1:0]   snap_vt_q, snap_vt_d, snap_va_q, snap_va_d;
  logic               snap_bad_q, snap_bad_d, pend_q, pend_d;
  logic [CNT_W-1:0]   meas_ht_q, meas_ht_d, meas_ha_q, meas_ha_d;
  logic [CNT_W-1:0]   meas_vt_q, meas_vt_d, meas_va_q, meas_va_d;
  logic               meas_valid_q, meas_valid_d, locked_q, locked_d, error_q, error_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [MW-1:0]      match_q, match_d;
  logic [4*CNT_W-1:0] exp_prev_q, exp_prev_d;

  logic [4*CNT_W-1:0] w_exp_cat;
  logic               w_len_bad, w_sat, w_timeout, w_match, w_exp_chg, w_err_set;

  assign w_exp_cat = {exp_htotal_i, exp_hactive_i, exp_vtotal_i, exp_vactive_i};
  assign w_exp_chg = (w_exp_cat != exp_prev_q);
  // A line only counts once it both started and ended on an hs rise.
  assign w_len_bad = w_hs_rise && seen_hs_q && len_vld_q && (pix_q != line_len_q);
  assign w_sat     = (pix_q == C_MAX) || (de_cnt_q == C_MAX) ||
                     (line_q == C_MAX) || (vact_q == C_MAX);
  assign w_timeout = ((line_q == C_MAX) && !w_vs_rise) || ((pix_q == C_MAX) && !w_hs_rise);
  assign w_match   = (snap_ht_q == exp_htotal_i) && (snap_ha_q == exp_hactive_i) &&
                     (snap_vt_q == exp_vtotal_i) && (snap_va_q == exp_vactive_i) && !snap_bad_q;

  always_comb begin
    pix_d = pix_q;  de_cnt_d = de_cnt_q;  line_d = line_q;  vact_d = vact_q;
    line_len_d = line_len_q;  act_len_d = act_len_q;
    seen_hs_d = seen_hs_q;  len_vld_d = len_vld_q;  line_bad_d = line_bad_q;
    state_d = state_q;
    snap_ht_d = snap_ht_q;  snap_ha_d = snap_ha_q;  snap_vt_d = snap_vt_q;  snap_va_d = snap_va_q;
    snap_bad_d = snap_bad_q;  pend_d = 1'b0;
    meas_ht_d = meas_ht_q;  meas_ha_d = meas_ha_q;  meas_vt_d = meas_vt_q;  meas_va_d = meas_va_q;
    meas_valid_d = 1'b0;  locked_d = locked_q;  error_d = error_q;
    frame_cnt_d = frame_cnt_q;  match_d = match_q;  exp_prev_d = w_exp_cat;
    w_err_set = 1'b0;

    if (w_hs_rise) begin
      pix_d     = CNT_W'(1);
      seen_hs_d = 1'b1;
      if (seen_hs_q) begin
        line_len_d = pix_q;
        len_vld_d  = 1'b1;
      end
    end else if (pix_q != C_MAX) begin
      pix_d = pix_q + 1'b1;
    end

    if (w_hs_rise)                             de_cnt_d = '0;
    else if (w_de_lvl && de_cnt_q != C_MAX)    de_cnt_d = de_cnt_q + 1'b1;
    if (w_de_fall)                             act_len_d = de_cnt_q;

    // An hs rise on the vs rise edge opens the new frame's first line.
    if (w_vs_rise) begin
      line_d     = w_hs_rise ? CNT_W'(1) : '0;
      vact_d     = w_de_rise ? CNT_W'(1) : '0;
      line_bad_d = 1'b0;
    end else begin
      if (w_hs_rise && line_q != C_MAX) line_d = line_q + 1'b1;
      if (w_de_rise && vact_q != C_MAX) vact_d = vact_q + 1'b1;
      line_bad_d = line_bad_q | w_len_bad | w_sat;
    end

    case (state_q)
      ST_IDLE: if (w_vs_rise) state_d = ST_ACQUIRE;
      ST_ACQUIRE, ST_MEASURE: begin
        if (w_vs_rise) begin
          snap_ht_d  = (w_hs_rise && seen_hs_q) ? pix_q : line_len_q;
          snap_ha_d  = act_len_q;
          snap_vt_d  = line_q;
          snap_va_d  = vact_q;
          snap_bad_d = line_bad_q | w_len_bad | w_sat;
          pend_d     = 1'b1;
          state_d    = ST_MEASURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pend_q) begin
      meas_ht_d    = snap_ht_q;
      meas_ha_d    = snap_ha_q;
      meas_vt_d    = snap_vt_q;
      meas_va_d    = snap_va_q;
      meas_valid_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 8'd1;
      if (w_match) begin
        if (match_q != C_LOCK) match_d = match_q + 1'b1;
        locked_d = (match_d == C_LOCK);
      end else begin
        match_d   = '0;
        locked_d  = 1'b0;
        w_err_set = 1'b1;
      end
    end

    if (w_exp_chg) begin
      locked_d = 1'b0;
      match_d  = '0;
    end

    if (w_timeout) begin
      pix_d = '0;  de_cnt_d = '0;  line_d = '0;  vact_d = '0;
      line_len_d = '0;  act_len_d = '0;
      seen_hs_d = 1'b0;  len_vld_d = 1'b0;  line_bad_d = 1'b0;
      state_d = ST_IDLE;  pend_d = 1'b0;
      locked_d = 1'b0;  match_d = '0;
      w_err_set = 1'b1;
    end

    if (w_err_set)        error_d = 1'b1;
    else if (clr_error_i) error_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;  de_cnt_q <= '0;  line_q <= '0;  vact_q <= '0;
      line_len_q <= '0;  act_len_q <= '0;
      seen_hs_q <= 1'b0;  len_vld_q <= 1'b0;  line_bad_q <= 1'b0;
      state_q <= ST_IDLE;
      snap_ht_q <= '0;  snap_ha_q <= '0;  snap_vt_q <= '0;  snap_va_q <= '0;
      snap_bad_q <= 1'b0;  pend_q <= 1'b0;
      meas_ht_q <= '0;  meas_ha_q <= '0;  meas_vt_q <= '0;  meas_va_q <= '0;
      meas_valid_q <= 1'b0;  locked_q <= 1'b0;  error_q <= 1'b0;
      frame_cnt_q <= '0;  match_q <= '0;  exp_prev_q <= '0;
    end else begin
      pix_q <= pix_d;  de_cnt_q <= de_cnt_d;  line_q <= line_d;  vact_q <= vact_d;
      line_len_q <= line_len_d;  act_len_q <= act_len_d;
      seen_hs_q <= seen_hs_d;  len_vld_q <= len_vld_d;  line_bad_q <= line_bad_d;
      state_q <= state_d;
      snap_ht_q <= snap_ht_d;  snap_ha_q <= snap_ha_d;  snap_vt_q <= snap_vt_d;  snap_va_q <= snap_va_d;
      snap_bad_q <= snap_bad_d;  pend_q <= pend_d;
      meas_ht_q <= meas_ht_d;  meas_ha_q <= meas_ha_d;  meas_vt_q <= meas_vt_d;  meas_va_q <= meas_va_d;
      meas_valid_q <= meas_valid_d;  locked_q <= locked_d;  error_q <= error_d;
      frame_cnt_q <= frame_cnt_d;  match_q <= match_d;  exp_prev_q <= exp_prev_d;
    end
  end

  assign meas_htotal_o  = meas_ht_q;
  assign meas_hactive_o = meas_ha_q;
  assign meas_vtotal_o  = meas_vt_q;
  assign meas_vactive_o = meas_va_q;
  assign meas_valid_o   = meas_valid_q;
  assign locked_o       = locked_q;
  assign error_o        = error_q;
  assign frame_cnt_o    = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mv_timing_monitor.sv
`default_nettype none
// =====================================================================
// tb_mv_timing_monitor : scoreboard bench on a small 16x6 raster
//                        (10x4 active), 12-bit counters.   Rev 1.0
// =====================================================================
module tb_mv_timing_monitor;

  localparam int CW = 12;
  localparam int HT = 16, HA = 10, VT = 6, VA = 4, DE_START = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          hs = 1'b0, vs = 1'b0, de = 1'b0, clr_error = 1'b0;
  logic [CW-1:0] exp_ht, exp_ha, exp_vt, exp_va;
  logic [CW-1:0] meas_ht, meas_ha, meas_vt, meas_va;
  logic          meas_valid, locked, error;
  logic [7:0]    frame_cnt;

  mv_timing_monitor #(.CNT_W(CW), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hs_i(hs), .vs_i(vs), .de_i(de),
    .exp_htotal_i(exp_ht), .exp_hactive_i(exp_ha),
    .exp_vtotal_i(exp_vt), .exp_vactive_i(exp_va),
    .clr_error_i(clr_error),
    .meas_htotal_o(meas_ht), .meas_hactive_o(meas_ha),
    .meas_vtotal_o(meas_vt), .meas_vactive_o(meas_va),
    .meas_valid_o(meas_valid), .locked_o(locked), .error_o(error),
    .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int ht; int ha; int vt; int va; int lk; int er; int fc;} exp_t;
  exp_t sb[$];
  exp_t e_cur;
  int   total = 0;
  int   bad   = 0;
  bit   prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int lk, input int er, input int fc);
    sb.push_back('{HT, HA, VT, VA, lk, er, fc});
  endtask

  // Monitor: pops one expectation per meas_valid pulse.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (meas_valid && prev_valid) begin
        total++; bad++;
        $display("FAIL meas_valid_width: high on 2 consecutive cycles, required 1");
      end
      if (meas_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_meas_valid: pulse with empty scoreboard at frame_cnt=%0d", frame_cnt);
        end else begin
          e_cur = sb.pop_front();
          chk("meas_htotal",  int'(meas_ht),   e_cur.ht);
          chk("meas_hactive", int'(meas_ha),   e_cur.ha);
          chk("meas_vtotal",  int'(meas_vt),   e_cur.vt);
          chk("meas_vactive", int'(meas_va),   e_cur.va);
          chk("locked",       int'(locked),    e_cur.lk);
          chk("error",        int'(error),     e_cur.er);
          chk("frame_cnt",    int'(frame_cnt), e_cur.fc);
        end
      end
    end
    prev_valid = meas_valid;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_meas_htotal"},  int'(meas_ht), 0);
    chk({tag, "_meas_hactive"}, int'(meas_ha), 0);
    chk({tag, "_meas_vtotal"},  int'(meas_vt), 0);
    chk({tag, "_meas_vactive"}, int'(meas_va), 0);
    chk({tag, "_meas_valid"},   int'(meas_valid), 0);
    chk({tag, "_locked"},       int'(locked), 0);
    chk({tag, "_error"},        int'(error), 0);
    chk({tag, "_frame_cnt"},    int'(frame_cnt), 0);
  endtask

  // hook: 1 clr_error pulse, 2 exp_hactive->6, 3 exp_hactive->HA, 4 async reset pulse
  task automatic do_hook(input int kind);
    case (kind)
      1: clr_error = 1'b1;
      2: exp_ha = CW'(6);
      3: exp_ha = CW'(HA);
      4: begin
        rst_n = 1'b0;
        #2;
        check_zero("midreset");
        #1;
        rst_n = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic drive_line(input int len, input bit vline, input bit aline, input int hook);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      clr_error = 1'b0;
      hs = (p < 2);
      vs = vline;
      de = aline && (p >= DE_START) && (p < DE_START + HA);
      if (p == 5 && hook != 0) do_hook(hook);
    end
  endtask

  task automatic drive_frame(input int bad_line, input int bad_len, input int hook_line, input int hook);
    for (int l = 0; l < VT; l++)
      drive_line((l == bad_line) ? bad_len : HT, l == 0, (l >= 1) && (l <= VA),
                 (l == hook_line) ? hook : 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, sb depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_ht = CW'(HT); exp_ha = CW'(HA); exp_vt = CW'(VT); exp_va = CW'(VA);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // nominal: first result at second vs rise, lock after third
    push(0, 0, 1);  drive_frame(-1, 0, -1, 0);
    push(1, 0, 2);  drive_frame(-1, 0, -1, 0);
    push(1, 0, 3);  drive_frame(-1, 0, -1, 0);
    push(1, 0, 4);  drive_frame(-1, 0, -1, 0);
    // one over-long line, lock returns after two clean frames, error sticky
    push(0, 1, 5);  drive_frame(2, HT + 1, -1, 0);
    push(0, 1, 6);  drive_frame(-1, 0, -1, 0);
    push(1, 1, 7);  drive_frame(-1, 0, -1, 0);
    chk("error_sticky", int'(error), 1);
    push(1, 0, 8);  drive_frame(-1, 0, 2, 1);
    chk("error_after_clr", int'(error), 0);
    // wrong expected hactive
    push(0, 1, 9);  drive_frame(-1, 0, 2, 2);
    chk("locked_after_exp_change", int'(locked), 0);
    push(0, 1, 10); drive_frame(-1, 0, -1, 0);
    chk("locked_wrong_exp", int'(locked), 0);
    push(0, 1, 11); drive_frame(-1, 0, 2, 3);
    push(1, 1, 12); drive_frame(-1, 0, -1, 0);
    push(1, 0, 13); drive_frame(-1, 0, 2, 1);
    // hs stuck low past counter saturation
    drive_frame(2, 5000, -1, 0);
    chk("timeout_error", int'(error), 1);
    chk("timeout_locked", int'(locked), 0);
    push(0, 1, 14); drive_frame(-1, 0, -1, 0);
    push(1, 1, 15); drive_frame(-1, 0, -1, 0);
    // async reset mid-frame, partial frame discarded
    drive_frame(-1, 0, 2, 4);
    push(0, 0, 1);  drive_frame(-1, 0, -1, 0);
    push(1, 0, 2);  drive_frame(-1, 0, -1, 0);
    // frame counter wrap
    for (int k = 3; k <= 256; k++) begin
      push(1, 0, k % 256);
      drive_frame(-1, 0, -1, 0);
    end
    drive_line(HT, 1'b1, 1'b0, 0);
    repeat (10) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    chk("frame_cnt_wrapped", int'(frame_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
